// File: rtl/mem_controller_if.sv
// Command, store-data and register-write bundle between the core control FSM
// and the memory-controller responder.
interface mem_controller_if #(
  parameter int DATA_W = 8,
  parameter int REG_AW = 2
);
  logic [2:0]        ctrl_data_contition;
  logic [5:0]        mc_data_length;
  logic [DATA_W-1:0] data_in;
  logic              data_in_valid;
  logic              data_in_ready;
  logic              reg_wr_en;
  logic [REG_AW-1:0] reg_wr_addr;
  logic [DATA_W-1:0] reg_wr_data;
  logic              mc_done;
  logic              mc_data_done;

  modport master (
    output ctrl_data_contition, mc_data_length, data_in, data_in_valid,
    input  data_in_ready, reg_wr_en, reg_wr_addr, reg_wr_data, mc_done, mc_data_done
  );

  modport slave (
    input  ctrl_data_contition, mc_data_length, data_in, data_in_valid,
    output data_in_ready, reg_wr_en, reg_wr_addr, reg_wr_data, mc_done, mc_data_done
  );
endinterface

// File: rtl/mem_controller.sv
// Memory-controller responder: stores input words into a 64-entry buffer and
// streams them out to the register file in chunks of REG_WORDS.
module mem_controller #(
  parameter int DATA_W    = 8,
  parameter int REG_WORDS = 4,
  parameter int REG_AW    = 2
) (
  input  logic            ctrl_clk,
  input  logic            ctrl_reset,
  mem_controller_if.slave bus
);

  typedef enum logic [1:0] {IDLE, STORE, XFER} state_e;

  localparam logic [2:0]        CMD_STORE = 3'b100;
  localparam logic [2:0]        CMD_XFER  = 3'b010;
  localparam logic [REG_AW-1:0] LAST_CNT  = REG_AW'(REG_WORDS - 1);

  state_e            state_q, state_d;
  logic [2:0]        prevCond_q;
  logic [5:0]        len_q, len_d;
  logic [5:0]        wrPtr_q, wrPtr_d;
  logic [5:0]        rdPtr_q, rdPtr_d;
  logic [REG_AW-1:0] cnt_q, cnt_d;
  logic              done_q, done_d;
  logic              dataDone_q, dataDone_d;
  logic              wrEn_q, wrEn_d;
  logic [REG_AW-1:0] wrAddr_q, wrAddr_d;
  logic [DATA_W-1:0] wrData_q, wrData_d;

  logic [DATA_W-1:0] bufMem [64];

  logic       cmdChanged;
  logic       storeStart;
  logic       xferStart;
  logic       accept;
  logic [5:0] rdNext;

  // A command only starts work on the cycle it changes, so a held level fires once.
  assign cmdChanged = (bus.ctrl_data_contition != prevCond_q);
  assign storeStart = (state_q == IDLE) && cmdChanged && (bus.ctrl_data_contition == CMD_STORE);
  assign xferStart  = (state_q == IDLE) && cmdChanged && (bus.ctrl_data_contition == CMD_XFER);
  assign accept     = (state_q == STORE) && bus.data_in_valid;
  assign rdNext     = rdPtr_q + 6'd1;

  always_ff @(posedge ctrl_clk or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      state_q    <= IDLE;
      prevCond_q <= 3'b000;
      len_q      <= '0;
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      cnt_q      <= '0;
      done_q     <= 1'b0;
      dataDone_q <= 1'b0;
      wrEn_q     <= 1'b0;
      wrAddr_q   <= '0;
      wrData_q   <= '0;
    end else begin
      state_q    <= state_d;
      prevCond_q <= bus.ctrl_data_contition;
      len_q      <= len_d;
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      dataDone_q <= dataDone_d;
      wrEn_q     <= wrEn_d;
      wrAddr_q   <= wrAddr_d;
      wrData_q   <= wrData_d;
    end
  end

  // Buffer contents deliberately survive reset.
  always_ff @(posedge ctrl_clk) begin
    if (accept) begin
      bufMem[wrPtr_q] <= bus.data_in;
    end
  end

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    wrPtr_d    = wrPtr_q;
    rdPtr_d    = rdPtr_q;
    cnt_d      = cnt_q;
    done_d     = 1'b0;
    dataDone_d = dataDone_q;
    wrEn_d     = 1'b0;
    wrAddr_d   = wrAddr_q;
    wrData_d   = wrData_q;

    case (state_q)
      IDLE: begin
        if (storeStart) begin
          len_d      = bus.mc_data_length;
          wrPtr_d    = '0;
          rdPtr_d    = '0;
          dataDone_d = 1'b0;
          if (bus.mc_data_length == 6'd0) begin
            done_d = 1'b1;
          end else begin
            state_d = STORE;
          end
        end else if (xferStart) begin
          // Nothing left to move: answer immediately so the core can stop asking.
          if (rdPtr_q == len_q) begin
            done_d     = 1'b1;
            dataDone_d = 1'b1;
          end else begin
            cnt_d   = '0;
            state_d = XFER;
          end
        end
      end

      STORE: begin
        if (accept) begin
          wrPtr_d = wrPtr_q + 6'd1;
          if (wrPtr_q == len_q - 6'd1) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end

      XFER: begin
        wrEn_d   = 1'b1;
        wrAddr_d = cnt_q;
        wrData_d = bufMem[rdPtr_q];
        rdPtr_d  = rdNext;
        cnt_d    = cnt_q + 1'b1;
        if ((cnt_q == LAST_CNT) || (rdNext == len_q)) begin
          done_d     = 1'b1;
          dataDone_d = (rdNext == len_q);
          state_d    = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.data_in_ready = (state_q == STORE);
  assign bus.reg_wr_en     = wrEn_q;
  assign bus.reg_wr_addr   = wrAddr_q;
  assign bus.reg_wr_data   = wrData_q;
  assign bus.mc_done       = done_q;
  assign bus.mc_data_done  = dataDone_q;

endmodule

// File: tb/tb_mem_controller.sv
// Self-checking bench for mem_controller: a transaction-level model schedules
// the expected outputs per cycle and one process compares them every cycle.
module tb_mem_controller;
  localparam int DATA_W    = 8;
  localparam int REG_WORDS = 4;
  localparam int REG_AW    = 2;
  localparam int NC        = 1024;

  logic ctrl_clk   = 1'b0;
  logic ctrl_reset = 1'b1;

  mem_controller_if #(.DATA_W(DATA_W), .REG_AW(REG_AW)) bus ();

  mem_controller #(.DATA_W(DATA_W), .REG_WORDS(REG_WORDS), .REG_AW(REG_AW)) dut (
    .ctrl_clk  (ctrl_clk),
    .ctrl_reset(ctrl_reset),
    .bus       (bus)
  );

  always #5 ctrl_clk = ~ctrl_clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int doneSeen = 0;
  int enSeen   = 0;
  int d0, e0;
  bit chkOn    = 1'b0;
  bit ddLevel  = 1'b0;

  // Expected outputs for the interval following rising edge number k.
  bit                expReady [NC];
  bit                expDone  [NC];
  bit                expEn    [NC];
  logic [REG_AW-1:0] expAddr  [NC];
  logic [DATA_W-1:0] expData  [NC];
  bit                ddChg    [NC];
  bit                ddVal    [NC];

  logic [DATA_W-1:0] modelMem [64];
  int modelLen = 0;
  int modelRd  = 0;

  always @(posedge ctrl_clk) cyc++;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s cycle=%0d actual=0x%0h expected=0x%0h", name, cyc, act, exp);
    end
  endtask

  always @(negedge ctrl_clk) begin
    if (ctrl_reset) begin
      ddLevel = 1'b0;
    end else if (chkOn && cyc < NC) begin
      if (ddChg[cyc]) ddLevel = ddVal[cyc];
      checkOutput("data_in_ready", 32'(bus.data_in_ready), 32'(expReady[cyc]));
      checkOutput("mc_done", 32'(bus.mc_done), 32'(expDone[cyc]));
      checkOutput("mc_data_done", 32'(bus.mc_data_done), 32'(ddLevel));
      checkOutput("reg_wr_en", 32'(bus.reg_wr_en), 32'(expEn[cyc]));
      if (expEn[cyc]) begin
        checkOutput("reg_wr_addr", 32'(bus.reg_wr_addr), 32'(expAddr[cyc]));
        checkOutput("reg_wr_data", 32'(bus.reg_wr_data), 32'(expData[cyc]));
      end
      if (bus.mc_done === 1'b1) doneSeen++;
      if (bus.reg_wr_en === 1'b1) enSeen++;
    end
  end

  task automatic tick();
    @(negedge ctrl_clk);
  endtask

  // Hold a command level with no data offered for n cycles.
  task automatic applyStimulus(input logic [2:0] cmd, input int n);
    bus.ctrl_data_contition = cmd;
    bus.data_in_valid       = 1'b0;
    repeat (n) tick();
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_ready"}, 32'(bus.data_in_ready), 32'd0);
    checkOutput({tag, "_done"},  32'(bus.mc_done), 32'd0);
    checkOutput({tag, "_dd"},    32'(bus.mc_data_done), 32'd0);
    checkOutput({tag, "_en"},    32'(bus.reg_wr_en), 32'd0);
    checkOutput({tag, "_addr"},  32'(bus.reg_wr_addr), 32'd0);
    checkOutput({tag, "_data"},  32'(bus.reg_wr_data), 32'd0);
  endtask

  // Store L words first, first+1, ...; alt offers a word only every other cycle.
  // abortAfter > 0 asserts reset once that many words were accepted.
  task automatic doStore(input int L, input logic [7:0] first, input bit alt, input int abortAfter);
    int t, d, j, idx;
    bit v;
    bus.ctrl_data_contition = 3'b100;
    bus.mc_data_length      = 6'(L);
    bus.data_in_valid       = 1'b0;
    t = cyc + 1;
    d = t;
    ddChg[t] = 1'b1;
    ddVal[t] = 1'b0;
    if (L == 0) begin
      expDone[t] = 1'b1;
    end else begin
      idx = 0;
      j   = 0;
      while (idx < L) begin
        expReady[t + j] = 1'b1;
        if (!alt || (j % 2 == 1)) begin
          idx++;
          if (idx == L) begin
            expDone[t + j + 1] = 1'b1;
            d = t + j + 1;
          end
        end
        j++;
      end
    end
    for (int i = 0; i < L; i++) modelMem[i] = first + 8'(i);
    modelLen = L;
    modelRd  = 0;
    tick();
    idx = 0;
    j   = 0;
    while (cyc < d) begin
      if (abortAfter > 0 && idx == abortAfter) begin
        for (int k = cyc + 1; k <= d; k++) begin
          expReady[k] = 1'b0;
          expDone[k]  = 1'b0;
          ddChg[k]    = 1'b0;
        end
        bus.ctrl_data_contition = 3'b000;
        bus.data_in_valid       = 1'b0;
        ctrl_reset              = 1'b1;
        modelLen = 0;
        modelRd  = 0;
        return;
      end
      v = !alt || (j % 2 == 1);
      bus.data_in_valid = v;
      bus.data_in       = v ? first + 8'(idx) : 8'hEE;
      if (v) idx++;
      j++;
      tick();
    end
    bus.data_in_valid = 1'b0;
  endtask

  // Request one chunk; returns no earlier than the chunk's mc_done cycle and
  // keeps the command (or midCmd once XFER is running) for at least hold cycles.
  task automatic doXfer(input int hold, input bit useMid, input logic [2:0] midCmd);
    int c0, t, n, d;
    c0 = cyc;
    bus.ctrl_data_contition = 3'b010;
    t = c0 + 1;
    if (modelRd == modelLen) begin
      expDone[t] = 1'b1;
      ddChg[t]   = 1'b1;
      ddVal[t]   = 1'b1;
      d = t;
    end else begin
      n = modelLen - modelRd;
      if (n > REG_WORDS) n = REG_WORDS;
      for (int i = 0; i < n; i++) begin
        expEn[t + 1 + i]   = 1'b1;
        expAddr[t + 1 + i] = REG_AW'(i);
        expData[t + 1 + i] = modelMem[modelRd + i];
      end
      d = t + n;
      expDone[d] = 1'b1;
      ddChg[d]   = 1'b1;
      ddVal[d]   = (modelRd + n == modelLen);
      modelRd += n;
    end
    while (cyc < d || (cyc - c0) < hold) begin
      tick();
      if (useMid && cyc == t + 1) bus.ctrl_data_contition = midCmd;
    end
  endtask

  initial begin
    bus.ctrl_data_contition = 3'b000;
    bus.mc_data_length      = 6'd0;
    bus.data_in             = '0;
    bus.data_in_valid       = 1'b0;
    repeat (2) tick();
    checkReset("reset");
    ctrl_reset = 1'b0;
    chkOn      = 1'b1;
    applyStimulus(3'b000, 2);

    // Store six words, then drain them in three transfer requests.
    d0 = doneSeen;
    doStore(6, 8'h10, 1'b0, 0);
    checkOutput("store6_done", 32'(bus.mc_done), 32'd1);
    checkOutput("store6_dd", 32'(bus.mc_data_done), 32'd0);
    e0 = enSeen;
    doXfer(0, 1'b0, 3'b000);
    checkOutput("chunk1_addr", 32'(bus.reg_wr_addr), 32'd3);
    checkOutput("chunk1_data", 32'(bus.reg_wr_data), 32'h13);
    checkOutput("chunk1_dd", 32'(bus.mc_data_done), 32'd0);
    applyStimulus(3'b001, 2);
    checkOutput("store6_chunk1_pulses", 32'(doneSeen - d0), 32'd2);
    checkOutput("chunk1_writes", 32'(enSeen - e0), 32'd4);

    e0 = enSeen;
    doXfer(0, 1'b0, 3'b000);
    checkOutput("chunk2_addr", 32'(bus.reg_wr_addr), 32'd1);
    checkOutput("chunk2_data", 32'(bus.reg_wr_data), 32'h15);
    checkOutput("chunk2_dd", 32'(bus.mc_data_done), 32'd1);
    applyStimulus(3'b001, 2);
    checkOutput("chunk2_writes", 32'(enSeen - e0), 32'd2);

    e0 = enSeen;
    d0 = doneSeen;
    doXfer(0, 1'b0, 3'b000);
    checkOutput("chunk3_done", 32'(bus.mc_done), 32'd1);
    checkOutput("chunk3_dd", 32'(bus.mc_data_done), 32'd1);
    applyStimulus(3'b001, 2);
    checkOutput("chunk3_writes", 32'(enSeen - e0), 32'd0);
    checkOutput("chunk3_pulses", 32'(doneSeen - d0), 32'd1);

    // Gappy valid, then an empty store followed by a transfer.
    doStore(3, 8'h30, 1'b1, 0);
    checkOutput("alt_done", 32'(bus.mc_done), 32'd1);
    checkOutput("alt_ready", 32'(bus.data_in_ready), 32'd0);
    applyStimulus(3'b001, 1);
    doStore(0, 8'h00, 1'b0, 0);
    checkOutput("empty_done", 32'(bus.mc_done), 32'd1);
    checkOutput("empty_ready", 32'(bus.data_in_ready), 32'd0);
    applyStimulus(3'b001, 1);
    e0 = enSeen;
    doXfer(0, 1'b0, 3'b000);
    checkOutput("empty_xfer_done", 32'(bus.mc_done), 32'd1);
    checkOutput("empty_xfer_dd", 32'(bus.mc_data_done), 32'd1);
    applyStimulus(3'b001, 2);
    checkOutput("empty_xfer_writes", 32'(enSeen - e0), 32'd0);

    // Held transfer command yields one chunk; a mid-XFER change is ignored.
    doStore(6, 8'h50, 1'b0, 0);
    applyStimulus(3'b001, 1);
    e0 = enSeen;
    d0 = doneSeen;
    doXfer(10, 1'b0, 3'b000);
    applyStimulus(3'b001, 1);
    checkOutput("held_writes", 32'(enSeen - e0), 32'd4);
    checkOutput("held_pulses", 32'(doneSeen - d0), 32'd1);
    e0 = enSeen;
    d0 = doneSeen;
    doXfer(0, 1'b1, 3'b100);
    checkOutput("mid_data", 32'(bus.reg_wr_data), 32'h55);
    applyStimulus(3'b100, 4);
    checkOutput("mid_writes", 32'(enSeen - e0), 32'd2);
    checkOutput("mid_pulses", 32'(doneSeen - d0), 32'd1);
    applyStimulus(3'b111, 2);
    applyStimulus(3'b000, 1);

    // Reset in the middle of a store, then a clean store and transfer.
    doStore(5, 8'h70, 1'b0, 2);
    tick();
    checkReset("abort");
    ctrl_reset = 1'b0;
    applyStimulus(3'b000, 2);
    doStore(3, 8'hA0, 1'b0, 0);
    applyStimulus(3'b001, 1);
    e0 = enSeen;
    doXfer(0, 1'b0, 3'b000);
    checkOutput("restart_addr", 32'(bus.reg_wr_addr), 32'd2);
    checkOutput("restart_data", 32'(bus.reg_wr_data), 32'hA2);
    checkOutput("restart_dd", 32'(bus.mc_data_done), 32'd1);
    applyStimulus(3'b001, 2);
    checkOutput("restart_writes", 32'(enSeen - e0), 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
